// File: rtl/menc_pkg.sv
// Shared types and helpers for the multi-hit encoder.
package menc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EMIT  = 2'd1,
    ST_EMPTY = 2'd2
  } menc_state_e;

  // Ceiling log2, usable in parameter elaboration.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Number of set bits in a vector of up to 64 bits.
  function automatic logic [6:0] popcount(input logic [63:0] v);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < 64; i++) c = c + 7'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/menc_pick.sv
// Combinational priority picker: index and one-hot mask of the priority set bit,
// plus a flag for "exactly one bit set".
module menc_pick #(
  parameter int unsigned N         = 8,
  parameter int unsigned MSB_FIRST = 0,
  parameter int unsigned W         = 3
) (
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] idx_o,
  output logic [N-1:0] mask_o,
  output logic         single_o
);

  // Scan in priority order; the first set bit wins.
  always_comb begin
    logic        found;
    int unsigned pos;
    found  = 1'b0;
    pos    = 0;
    idx_o  = '0;
    mask_o = '0;
    for (int k = 0; k < N; k++) begin
      pos = (MSB_FIRST != 0) ? (N - 1 - k) : k;
      if (!found && vec_i[pos]) begin
        found       = 1'b1;
        idx_o       = W'(pos);
        mask_o[pos] = 1'b1;
      end
    end
  end

  // Clearing the lowest set bit leaves zero only for a power of two.
  assign single_o = (vec_i != '0) &&
                    ((vec_i & (vec_i - {{(N-1){1'b0}}, 1'b1})) == '0);

endmodule

// File: rtl/multi_hit_encoder.sv
// Sequential multi-hit encoder: accepts an N-bit request vector and emits the index of
// each set bit, one per beat, in priority order. Optional popcount output enabled by
// defining MULTI_HIT_ENCODER_COUNT_EN.
module multi_hit_encoder
  import menc_pkg::*;
#(
  parameter int unsigned N         = 8,
  parameter int unsigned W         = clog2(N),
  parameter int unsigned MSB_FIRST = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         EN,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [N-1:0] IN,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] Y,
  output logic         none,
`ifdef MULTI_HIT_ENCODER_COUNT_EN
  output logic [W:0]   cnt,
`endif
  output logic         Done
);

  menc_state_e  state_q, state_d;
  logic [N-1:0] pend_q, pend_d;
  logic [W-1:0] y_q, y_d;
  logic         none_q, none_d;
  logic         done_q, done_d;
  logic         vld_q, vld_d;

  logic [W-1:0] cur_idx, nxt_idx;
  logic [N-1:0] cur_mask, nxt_mask;
  logic         cur_single, nxt_single;
  logic [N-1:0] pick_vec;
  logic         unused_pick;

  // Current beat: identifies the bit to clear on handshake.
  menc_pick #(
    .N        (N),
    .MSB_FIRST(MSB_FIRST),
    .W        (W)
  ) u_pick_cur (
    .vec_i   (pend_q),
    .idx_o   (cur_idx),
    .mask_o  (cur_mask),
    .single_o(cur_single)
  );

  // Next beat: the freshly offered vector in IDLE, else what remains after this beat.
  assign pick_vec = (state_q == ST_IDLE) ? IN : (pend_q & ~cur_mask);

  menc_pick #(
    .N        (N),
    .MSB_FIRST(MSB_FIRST),
    .W        (W)
  ) u_pick_nxt (
    .vec_i   (pick_vec),
    .idx_o   (nxt_idx),
    .mask_o  (nxt_mask),
    .single_o(nxt_single)
  );

  assign unused_pick = ^{cur_idx, nxt_mask};

  // Handshake outputs; EN low hides the beat without disturbing it.
  assign in_rdy  = EN && (state_q == ST_IDLE);
  assign out_vld = EN && vld_q;
  assign Y       = y_q;
  assign none    = none_q;
  assign Done    = done_q;

`ifdef MULTI_HIT_ENCODER_COUNT_EN
  logic [W:0] cnt_q, cnt_d;
  assign cnt = cnt_q;
`endif

  // Next-state: accept in IDLE, step through set bits in EMIT, single beat in EMPTY.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    y_d     = y_q;
    none_d  = none_q;
    done_d  = done_q;
    vld_d   = vld_q;
`ifdef MULTI_HIT_ENCODER_COUNT_EN
    cnt_d   = cnt_q;
`endif
    if (EN) begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_vld) begin
            pend_d = IN;
            vld_d  = 1'b1;
`ifdef MULTI_HIT_ENCODER_COUNT_EN
            cnt_d  = (W+1)'(popcount(64'(IN)));
`endif
            if (IN == '0) begin
              state_d = ST_EMPTY;
              y_d     = '0;
              none_d  = 1'b1;
              done_d  = 1'b1;
            end else begin
              state_d = ST_EMIT;
              y_d     = nxt_idx;
              none_d  = 1'b0;
              done_d  = nxt_single;
            end
          end
        end
        ST_EMIT: begin
          if (out_vld && out_rdy) begin
            pend_d = pend_q & ~cur_mask;
            if (cur_single) begin
              state_d = ST_IDLE;
              vld_d   = 1'b0;
            end else begin
              y_d    = nxt_idx;
              done_d = nxt_single;
            end
          end
        end
        ST_EMPTY: begin
          if (out_vld && out_rdy) begin
            state_d = ST_IDLE;
            vld_d   = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          vld_d   = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      y_q     <= '0;
      none_q  <= 1'b0;
      done_q  <= 1'b0;
      vld_q   <= 1'b0;
`ifdef MULTI_HIT_ENCODER_COUNT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      y_q     <= y_d;
      none_q  <= none_d;
      done_q  <= done_d;
      vld_q   <= vld_d;
`ifdef MULTI_HIT_ENCODER_COUNT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_multi_hit_encoder.sv
// Directed bench for multi_hit_encoder: one LSB-first and one MSB-first instance.
module tb_multi_hit_encoder;

  logic       clk = 1'b0;
  logic       rst, EN, out_rdy;
  logic [7:0] IN;
  logic       in_vld_l, in_rdy_l, out_vld_l, none_l, done_l;
  logic [2:0] y_l;
  logic       in_vld_m, in_rdy_m, out_vld_m, none_m, done_m;
  logic [2:0] y_m;
`ifdef MULTI_HIT_ENCODER_COUNT_EN
  logic [3:0] cnt_l, cnt_m;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multi_hit_encoder #(.N(8), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst(rst), .EN(EN), .in_vld(in_vld_l), .in_rdy(in_rdy_l), .IN(IN),
    .out_vld(out_vld_l), .out_rdy(out_rdy), .Y(y_l), .none(none_l),
`ifdef MULTI_HIT_ENCODER_COUNT_EN
    .cnt(cnt_l),
`endif
    .Done(done_l)
  );

  multi_hit_encoder #(.N(8), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rst(rst), .EN(EN), .in_vld(in_vld_m), .in_rdy(in_rdy_m), .IN(IN),
    .out_vld(out_vld_m), .out_rdy(out_rdy), .Y(y_m), .none(none_m),
`ifdef MULTI_HIT_ENCODER_COUNT_EN
    .cnt(cnt_m),
`endif
    .Done(done_m)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; EN = 1'b1; out_rdy = 1'b1; IN = '0; in_vld_l = 1'b0; in_vld_m = 1'b0;
    tick();
    tick();
    checks++; if (out_vld_l !== 1'b0) begin errors++; $display("FAIL reset_out_vld: got %b want 0", out_vld_l); end
    checks++; if (y_l !== 3'd0) begin errors++; $display("FAIL reset_y: got %0d want 0", y_l); end
    checks++; if ({none_l, done_l} !== 2'b00) begin errors++; $display("FAIL reset_none_done: got %b want 00", {none_l, done_l}); end
    checks++; if (in_rdy_l !== 1'b1) begin errors++; $display("FAIL reset_in_rdy: got %b want 1", in_rdy_l); end
    checks++; if (out_vld_m !== 1'b0) begin errors++; $display("FAIL reset_m_out_vld: got %b want 0", out_vld_m); end
`ifdef MULTI_HIT_ENCODER_COUNT_EN
    checks++; if (cnt_l !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", cnt_l); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_empty();
    out_rdy = 1'b0; IN = 8'h00; in_vld_l = 1'b1;
    tick();
    in_vld_l = 1'b0;
    checks++; if ({out_vld_l, y_l, none_l, done_l} !== {1'b1, 3'd0, 1'b1, 1'b1})
      begin errors++; $display("FAIL empty_beat: got vld/y/none/done=%b/%0d/%b/%b want 1/0/1/1", out_vld_l, y_l, none_l, done_l); end
    checks++; if (in_rdy_l !== 1'b0) begin errors++; $display("FAIL empty_in_rdy_busy: got %b want 0", in_rdy_l); end
`ifdef MULTI_HIT_ENCODER_COUNT_EN
    checks++; if (cnt_l !== 4'd0) begin errors++; $display("FAIL empty_cnt: got %0d want 0", cnt_l); end
`endif
    out_rdy = 1'b1;
    tick();
    checks++; if ({out_vld_l, in_rdy_l} !== 2'b01) begin errors++; $display("FAIL empty_release: got vld/rdy=%b want 01", {out_vld_l, in_rdy_l}); end
  endtask

  task automatic test_lsb_order();
    logic [2:0] exp_y [4];
    exp_y[0] = 3'd0; exp_y[1] = 3'd2; exp_y[2] = 3'd5; exp_y[3] = 3'd7;
    out_rdy = 1'b1; IN = 8'b1010_0101; in_vld_l = 1'b1;
    tick();
    in_vld_l = 1'b0; IN = 8'hFF;  // must be ignored while busy
    for (int i = 0; i < 4; i++) begin
      checks++; if ({out_vld_l, y_l, done_l, in_rdy_l} !== {1'b1, exp_y[i], (i == 3), 1'b0})
        begin errors++; $display("FAIL lsb_beat%0d: got vld/y/done/rdy=%b/%0d/%b/%b want 1/%0d/%b/0", i, out_vld_l, y_l, done_l, in_rdy_l, exp_y[i], (i == 3)); end
`ifdef MULTI_HIT_ENCODER_COUNT_EN
      checks++; if (cnt_l !== 4'd4) begin errors++; $display("FAIL lsb_cnt%0d: got %0d want 4", i, cnt_l); end
`endif
      tick();
    end
    checks++; if ({out_vld_l, in_rdy_l} !== 2'b01) begin errors++; $display("FAIL lsb_end: got vld/rdy=%b want 01", {out_vld_l, in_rdy_l}); end
  endtask

  task automatic test_msb_order();
    out_rdy = 1'b1; IN = 8'b0000_1001; in_vld_m = 1'b1;
    tick();
    in_vld_m = 1'b0;
    checks++; if ({out_vld_m, y_m, done_m} !== {1'b1, 3'd3, 1'b0})
      begin errors++; $display("FAIL msb_beat0: got vld/y/done=%b/%0d/%b want 1/3/0", out_vld_m, y_m, done_m); end
`ifdef MULTI_HIT_ENCODER_COUNT_EN
    checks++; if (cnt_m !== 4'd2) begin errors++; $display("FAIL msb_cnt0: got %0d want 2", cnt_m); end
`endif
    tick();
    checks++; if ({out_vld_m, y_m, done_m} !== {1'b1, 3'd0, 1'b1})
      begin errors++; $display("FAIL msb_beat1: got vld/y/done=%b/%0d/%b want 1/0/1", out_vld_m, y_m, done_m); end
`ifdef MULTI_HIT_ENCODER_COUNT_EN
    checks++; if (cnt_m !== 4'd2) begin errors++; $display("FAIL msb_cnt1: got %0d want 2", cnt_m); end
`endif
    tick();
    checks++; if ({out_vld_m, in_rdy_m} !== 2'b01) begin errors++; $display("FAIL msb_end: got vld/rdy=%b want 01", {out_vld_m, in_rdy_m}); end
  endtask

  task automatic test_backpressure();
    out_rdy = 1'b0; IN = 8'b0110_0000; in_vld_l = 1'b1;
    tick();
    in_vld_l = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if ({out_vld_l, y_l, done_l} !== {1'b1, 3'd5, 1'b0})
        begin errors++; $display("FAIL bp_hold%0d: got vld/y/done=%b/%0d/%b want 1/5/0", i, out_vld_l, y_l, done_l); end
      if (i < 3) tick();
    end
    out_rdy = 1'b1;
    tick();
    checks++; if ({out_vld_l, y_l, done_l} !== {1'b1, 3'd6, 1'b1})
      begin errors++; $display("FAIL bp_release: got vld/y/done=%b/%0d/%b want 1/6/1", out_vld_l, y_l, done_l); end
    tick();
    checks++; if (out_vld_l !== 1'b0) begin errors++; $display("FAIL bp_end: got %b want 0", out_vld_l); end
  endtask

  task automatic test_en_stall();
    out_rdy = 1'b1; IN = 8'b1000_0010; in_vld_l = 1'b1;
    tick();
    in_vld_l = 1'b0;
    checks++; if ({out_vld_l, y_l, done_l} !== {1'b1, 3'd1, 1'b0})
      begin errors++; $display("FAIL en_first: got vld/y/done=%b/%0d/%b want 1/1/0", out_vld_l, y_l, done_l); end
    tick();
    EN = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if ({out_vld_l, in_rdy_l, y_l} !== {1'b0, 1'b0, 3'd7})
        begin errors++; $display("FAIL en_stall%0d: got vld/rdy/y=%b/%b/%0d want 0/0/7", i, out_vld_l, in_rdy_l, y_l); end
      tick();
    end
    EN = 1'b1;
    #1;
    checks++; if ({out_vld_l, y_l, done_l} !== {1'b1, 3'd7, 1'b1})
      begin errors++; $display("FAIL en_resume: got vld/y/done=%b/%0d/%b want 1/7/1", out_vld_l, y_l, done_l); end
    tick();
    checks++; if ({out_vld_l, in_rdy_l} !== 2'b01) begin errors++; $display("FAIL en_end: got vld/rdy=%b want 01", {out_vld_l, in_rdy_l}); end
  endtask

  task automatic test_reset_mid_scan();
    out_rdy = 1'b1; IN = 8'hFF; in_vld_l = 1'b1;
    tick();
    in_vld_l = 1'b0;
    checks++; if ({out_vld_l, y_l} !== {1'b1, 3'd0}) begin errors++; $display("FAIL rstmid_first: got vld/y=%b/%0d want 1/0", out_vld_l, y_l); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({out_vld_l, in_rdy_l, y_l, done_l} !== {1'b0, 1'b1, 3'd0, 1'b0})
      begin errors++; $display("FAIL rstmid_state: got vld/rdy/y/done=%b/%b/%0d/%b want 0/1/0/0", out_vld_l, in_rdy_l, y_l, done_l); end
    IN = 8'b0001_0000; in_vld_l = 1'b1;
    tick();
    in_vld_l = 1'b0;
    checks++; if ({out_vld_l, y_l, none_l, done_l} !== {1'b1, 3'd4, 1'b0, 1'b1})
      begin errors++; $display("FAIL rstmid_new: got vld/y/none/done=%b/%0d/%b/%b want 1/4/0/1", out_vld_l, y_l, none_l, done_l); end
    tick();
    checks++; if (out_vld_l !== 1'b0) begin errors++; $display("FAIL rstmid_end: got %b want 0", out_vld_l); end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_lsb_order();
    test_msb_order();
    test_backpressure();
    test_en_stall();
    test_reset_mid_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multi_hit_encoder.md
Name: multi_hit_encoder

Overview:
- Parametrised sequential successor to the team's 8-to-3 enable/done encoder.
- Accepts an N-bit request vector through a valid/ready handshake and emits the index of every set bit, one per output beat, in priority order.
- Flags the last beat with done and reports an all-zero vector with none.
- Sits between request-collecting logic (interrupt/request lines) and a downstream consumer that services one index at a time.

Parameters:
- N, 8, width of the input vector; legal range 2..64.
- W, $clog2(N), index width; derived, do not override.
- MSB_FIRST, 0, 0 = lowest set bit first, 1 = highest set bit first.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- EN  input  1  global enable; low stalls the block.
- in_vld  input  1  a vector is offered on IN.
- in_rdy  output  1  block can accept a vector.
- IN  input  N  request vector.
- out_vld  output  1  Y/none/Done are valid.
- out_rdy  input  1  downstream accepts the current beat.
- Y  output  W  index of the current set bit.
- none  output  1  accepted vector was all zero.
- Done  output  1  current beat is the last for this vector.

Behaviour:
- One clock; reset is synchronous and active-high on rst, sampled at the rising edge of clk.
- Reset values: state IDLE, pending=0, out_vld=0, Y=0, none=0, Done=0. in_rdy=1 in the first cycle after reset if EN=1.
- States:
  - IDLE: in_rdy = EN. On in_vld && in_rdy, latch IN into pending and go to EMIT; out_vld=1 on the next cycle (latency 1).
  - EMIT: Y = index of the priority bit of pending (LSB or MSB per MSB_FIRST). Done=1 when pending has exactly one set bit. none=0.
    - On out_vld && out_rdy: clear that bit. If it was the last bit, return to IDLE, otherwise stay in EMIT with the next index on the following cycle.
  - EMPTY: entered when the accepted vector is zero. Emits one beat: Y=0, none=1, Done=1. On handshake, return to IDLE.
- Outputs Y, none, Done and out_vld are registered; no combinational path from IN to outputs.
- Throughput: one index per cycle with out_rdy held high, plus one IDLE cycle between vectors. in_rdy=0 outside IDLE, so there is no same-cycle accept on the final beat.
- Backpressure: while out_vld=1 && out_rdy=0, Y/none/Done are held stable.
- EN=0: all state frozen, in_rdy=0, out_vld=0 (outputs other than out_vld keep their values). On EN=1 the block resumes with the same pending beat.
- rst asserted mid-vector: pending discarded, next-cycle state equals the reset values. No partial beat is emitted.
- IN is ignored whenever in_rdy=0. in_vld may be withdrawn before acceptance.

Optional Feature:
- Macro MULTI_HIT_ENCODER_COUNT_EN.
- Defined: adds output cnt, width W+1, holding the popcount of the accepted vector.
  - Registered at accept and valid for every beat of that vector; 0 for an empty vector.
  - Reset value 0.
- Undefined: port and popcount logic absent; all other behaviour identical.

Decomposition:
- Package menc_pkg holds:
  - state encoding constants ST_IDLE, ST_EMIT, ST_EMPTY;
  - a clog2 function;
  - a popcount function used by the optional feature.
- One sub-module, menc_pick: combinational, parametrised N/MSB_FIRST. Takes pending and returns the priority index, a one-hot mask of that bit, and a "single bit left" flag.
- The top level holds the FSM, the pending register and the handshake.

Test Plan:
- Empty vector: rst 2 cycles, EN=1, IN=8'h00 with in_vld=1 → next cycle out_vld=1, Y=0, none=1, Done=1; then in_rdy=1.
- LSB order: IN=8'b1010_0101, out_rdy=1 → Y=0,2,5,7 on 4 consecutive cycles, Done only with Y=7; in_rdy=0 during those cycles.
- MSB order: MSB_FIRST=1, IN=8'b0000_1001 → Y=3 then Y=0 with Done=1. With MULTI_HIT_ENCODER_COUNT_EN defined, cnt=2 on both beats.
- Backpressure: IN=8'b0110_0000, out_rdy=0 for 3 cycles on the first beat → Y=5 held, out_vld=1 held; after release Y=6 with Done=1.
- EN stall: EN=0 for 2 cycles after the first beat of 8'b1000_0010 → out_vld=0, in_rdy=0; EN=1 → Y=7, Done=1.
- Reset mid-scan: rst for 1 cycle after Y=0 of 8'hFF → next cycle out_vld=0, in_rdy=1. A new IN=8'b0001_0000 then yields Y=4 with Done=1.
